handshake_sink_checker: RTL

HANDSHAKE_SINK_CHECKER -- requirements
Module: handshake_sink_checker

---
 rtl/handshake_sink_checker.sv | 97 +++++++++
 1 files changed

// File: rtl/handshake_sink_checker.sv
// Valid/ready token sink: counts fixed-size batches and reports each one.
// Define HANDSHAKE_SINK_CHECKER_MISMATCH_EN to check tokens against EXPECTED.
module handshake_sink_checker #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] EXPECTED = DATA_WIDTH'(8'hFF),
  parameter int TOKEN_COUNT = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [CNT_WIDTH-1:0]  done_count,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic                  mismatch,
  output logic [CNT_WIDTH-1:0]  mismatch_index
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TOKEN_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] TC   = CNT_WIDTH'(TOKEN_COUNT);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  typedef enum logic {
    ACCEPT = 1'b0,
    REPORT = 1'b1
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] done_count_q;

  // Handshake outputs depend on the state register alone.
  assign ins_ready  = (state == ACCEPT);
  assign done_valid = (state == REPORT);
  assign done_count = done_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ACCEPT;
      cnt          <= '0;
      done_count_q <= '0;
    end else begin
      unique case (state)
        ACCEPT: begin
          if (ins_valid) begin
            if (cnt == LAST) begin
              state        <= REPORT;
              done_count_q <= TC;
            end
            cnt <= cnt + ONE;
          end
        end
        REPORT: begin
          if (done_ready) begin
            state        <= ACCEPT;
            cnt          <= '0;
            done_count_q <= '0;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

`ifdef HANDSHAKE_SINK_CHECKER_MISMATCH_EN
  logic                 mm_q;
  logic [CNT_WIDTH-1:0] mm_idx_q;

  assign mismatch       = mm_q;
  assign mismatch_index = mm_idx_q;

  // Only the first bad token of a batch is recorded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mm_q     <= 1'b0;
      mm_idx_q <= '0;
    end else if (state == REPORT) begin
      if (done_ready) begin
        mm_q     <= 1'b0;
        mm_idx_q <= '0;
      end
    end else if (ins_valid && !mm_q && ins != EXPECTED) begin
      mm_q     <= 1'b1;
      mm_idx_q <= cnt;
    end
  end
`else
  logic unused_ins;

  assign unused_ins     = ^ins;
  assign mismatch       = 1'b0;
  assign mismatch_index = '0;
`endif

endmodule
